// File: rtl/snn_image_sequencer.sv
// snn_image_sequencer: receives an image over the UART, unpacks it into the
// input-unit RAM one pixel bit per cycle, starts snn_core, then sends the
// classified digit back as a single ASCII byte.
// Optional macro SNN_SEQ_TIMEOUT_EN adds a core_done watchdog that reports 8'hFF.
module snn_image_sequencer #(
  parameter int          N_BYTES      = 98,
  parameter logic [19:0] DONE_TIMEOUT = 20'd1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_clr,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic       ram_data,
  input  logic [9:0] core_addr,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       busy
);

  localparam int BW = $clog2(N_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_RX_WAIT, S_START, S_WAIT_DONE, S_TX
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    tx_data_q, tx_data_d;
`ifdef SNN_SEQ_TIMEOUT_EN
  logic [19:0]   to_cnt_q, to_cnt_d;
`endif

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
`ifdef SNN_SEQ_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
`ifdef SNN_SEQ_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  // Next-state and pulse outputs; pulses are forced low while reset is held
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
`ifdef SNN_SEQ_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    rx_clr     = 1'b0;
    ram_we     = 1'b0;
    core_start = 1'b0;
    tx_start   = 1'b0;
    case (state_q)
      S_IDLE, S_RX_WAIT: begin
        if (rx_rdy) begin
          shift_d = rx_data;
          rx_clr  = 1'b1;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        // One pixel per cycle, LSB first
        ram_we    = 1'b1;
        shift_d   = {1'b0, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_cnt_d = byte_cnt_q + BW'(1);
          state_d    = (byte_cnt_q == BW'(N_BYTES - 1)) ? S_START : S_RX_WAIT;
        end
      end
      S_START: begin
        core_start = 1'b1;
        byte_cnt_d = '0;
`ifdef SNN_SEQ_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        state_d    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // rx_rdy is deliberately not serviced here; the byte stays pending
        if (core_done) begin
          tx_data_d = 8'h30 + {4'h0, core_digit};
          state_d   = S_TX;
        end
`ifdef SNN_SEQ_TIMEOUT_EN
        else if (to_cnt_q == DONE_TIMEOUT - 20'd1) begin
          tx_data_d = 8'hFF;
          state_d   = S_TX;
        end else begin
          to_cnt_d = to_cnt_q + 20'd1;
        end
`endif
      end
      S_TX: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      rx_clr     = 1'b0;
      ram_we     = 1'b0;
      core_start = 1'b0;
      tx_start   = 1'b0;
    end
  end

  // RAM address belongs to the loader only while unpacking
  assign ram_addr = (state_q == S_UNPACK) ? 10'({byte_cnt_q, bit_cnt_q}) : core_addr;
  assign ram_data = shift_q[0];
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_snn_image_sequencer.sv
// Directed bench for snn_image_sequencer: byte-vector and result tables plus
// hand-written reset-mid-frame and optional timeout sequences.
module tb_snn_image_sequencer;

  localparam int NB = 98;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_clr;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_data;
  logic [9:0] core_addr = 10'h2AA;
  logic       core_start;
  logic       core_done = 1'b0;
  logic [3:0] core_digit = 4'h0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       busy;

  snn_image_sequencer #(.N_BYTES(NB), .DONE_TIMEOUT(20'(TO))) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_clr(rx_clr),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .core_addr(core_addr),
    .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_start = 0;

  always @(posedge clk) if (core_start === 1'b1) n_start <= n_start + 1;

  // Byte stimulus with the expected pixel order written out by hand (first written bit leftmost)
  typedef struct { logic [7:0] b; logic [0:7] seq; } bvec_t;
  // Result stimulus: digit, cycles tx_busy stays high, expected ASCII byte
  typedef struct { logic [3:0] digit; int busy_cyc; logic [7:0] exp_tx; } rvec_t;
  bvec_t bv[6];
  rvec_t rv[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [0:7] seq, input int base, input int gap);
    int n;
    repeat (gap) step;
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    n = 0;
    while (rx_clr !== 1'b1 && n < 20) begin
      step; #1; n++;
    end
    chk("rx_clr_seen", rx_clr, 1);
    step;
    rx_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("ram_we", ram_we, 1);
      chk("ram_addr", ram_addr, 32'(base + i));
      chk("ram_data", ram_data, seq[i]);
      chk("rx_clr_once", rx_clr, 0);
      step;
    end
  endtask

  task automatic run_frame(input int nb);
    for (int k = 0; k < nb; k++) send_byte(bv[k % 6].b, bv[k % 6].seq, k * 8, 3);
    if (nb == NB) begin
      #1;
      chk("core_start_after_last", core_start, 1);
      chk("ram_we_start", ram_we, 0);
      chk("addr_mux_start", ram_addr, 10'h2AA);
      step; #1;
      chk("core_start_single", core_start, 0);
    end
  endtask

  task automatic result(input logic [3:0] d, input int bc, input logic [7:0] exp);
    rx_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("rx_ignored_wait_done", rx_clr, 0);
      chk("busy_wait_done", busy, 1);
      step;
    end
    rx_rdy     = 1'b0;
    tx_busy    = (bc > 0);
    core_done  = 1'b1;
    core_digit = d;
    step;
    core_done = 1'b0;
    for (int j = 0; j < bc; j++) begin
      #1;
      chk("tx_start_held", tx_start, 0);
      step;
    end
    tx_busy = 1'b0;
    #1;
    chk("tx_start", tx_start, 1);
    chk("tx_data", tx_data, exp);
    step; #1;
    chk("busy_after_tx", busy, 0);
    chk("tx_start_single", tx_start, 0);
    core_done = 1'b1;
    step;
    core_done = 1'b0;
    #1;
    chk("done_in_idle_busy", busy, 0);
    chk("done_in_idle_tx", tx_start, 0);
  endtask

  initial begin
    int s0;
    bv[0] = '{8'hA5, 8'b10100101};
    bv[1] = '{8'h01, 8'b10000000};
    bv[2] = '{8'h80, 8'b00000001};
    bv[3] = '{8'h3C, 8'b00111100};
    bv[4] = '{8'hF0, 8'b00001111};
    bv[5] = '{8'h12, 8'b01001000};
    rv[0] = '{4'd7,  0, 8'h37};
    rv[1] = '{4'd0,  5, 8'h30};
    rv[2] = '{4'd9,  0, 8'h39};
    rv[3] = '{4'd10, 2, 8'h3A};
    rv[4] = '{4'd15, 0, 8'h3F};

    // Reset, with a pending byte that must not be consumed
    rst_n  = 1'b0;
    rx_rdy = 1'b1;
    step; step; #1;
    chk("rst_rx_clr", rx_clr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_addr_mux", ram_addr, 10'h2AA);
    rx_rdy = 1'b0;
    rst_n  = 1'b1;
    step;

    for (int r = 0; r < 5; r++) begin
      s0 = n_start;
      run_frame(NB);
      result(rv[r].digit, rv[r].busy_cyc, rv[r].exp_tx);
      chk("start_count", 32'(n_start - s0), 1);
    end

    // Reset after 40 bytes; the next frame must start at address 0
    s0 = n_start;
    run_frame(40);
    rst_n = 1'b0;
    step; #1;
    chk("midrst_busy", busy, 0);
    rst_n = 1'b1;
    step;
    chk("midrst_no_start", 32'(n_start - s0), 0);
    run_frame(NB);
    result(4'd3, 0, 8'h33);
    chk("midrst_start_count", 32'(n_start - s0), 1);

`ifdef SNN_SEQ_TIMEOUT_EN
    begin
      int n;
      run_frame(NB);
      n = 1;
      #1;
      while (tx_start !== 1'b1 && n < 400) begin
        step; #1; n++;
      end
      chk("timeout_cycle", 32'(n), 32'(TO + 1));
      chk("timeout_code", tx_data, 8'hFF);
      step;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
